four_bit_down_counter: RTL and testbench
========================================

FOUR_BIT_DOWN_COUNTER -- requirements
Module: four_bit_down_counter

Interface
REQ-001 SHALL provide port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL provide port: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL provide port: en  input  1  count enable; 1 = decrement on this edge.
REQ-004 SHALL provide port: load  input  1  synchronous load/start strobe.
REQ-005 SHALL provide port: b  input  4  start/reload value, captured on load.
REQ-006 SHALL provide port: l  input  4  terminal (lower-limit) value, captured on load.
REQ-007 SHALL provide port: auto  input  1  1 = auto-reload at terminal; 0 = one-shot; captured on load.
REQ-008 SHALL provide port: d  output  4  current count, registered.
REQ-009 SHALL provide port: tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-010 SHALL provide port: busy  output  1  1 while in RUN state, registered.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE; busy = 1 only in RUN.
REQ-012 load = 1 at an edge, in any state: d <= b, b_q <= b, l_q <= l, auto_q <= auto, state <= RUN, tc <= 0.
REQ-013 load SHALL take priority over en and over the terminal condition on the same edge; no tc is generated on that edge.
REQ-014 In RUN with en = 1 and d != l_q: d <= d - 1 modulo 16 (0 wraps to 15), tc <= 0.
REQ-015 In RUN with en = 1 and d == l_q: tc <= 1 on that edge only.
REQ-016 On that terminal edge with auto_q = 1: d <= b_q and state stays RUN.
REQ-017 On that terminal edge with auto_q = 0: d holds l_q and state <= DONE.
REQ-018 With en = 0 in RUN: d and state SHALL hold and tc <= 0.
REQ-019 In IDLE and DONE: d holds, tc <= 0, en is ignored; only load leaves these states.
REQ-020 If b == l at load: the first enabled edge after load is the terminal edge, giving 1 enabled cycle per period.
REQ-021 For b != l: the period SHALL be ((b - l) mod 16) + 1 enabled cycles; b < l counts down through the 0->15 wrap.
REQ-022 Changes on b, l or auto while in RUN SHALL have no effect until the next load.
REQ-023 tc SHALL never be high for two consecutive cycles unless the period is 1 (b == l, auto = 1, en held high).

Reset
REQ-024 rst = 0 SHALL immediately, independent of clk, set d = 0, tc = 0, busy = 0, state = IDLE, and clear b_q, l_q, auto_q to 0.
REQ-025 Reset asserted mid-count SHALL abort the count with no tc; after release the block stays IDLE until load.
REQ-026 The first edge after rst deasserts SHALL be a normal functional edge; load on that edge is honoured.

Structure
REQ-027 A shared package SHALL hold the width constant CNT_W = 4 and the state encoding (IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10).
REQ-028 The block SHALL be a single module with one sequential process and next-state logic; no sub-module is warranted.
REQ-029 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-030 Bench SHALL cover one-shot: rst release, load b = 10, l = 3, auto = 0, en = 1 -> d = 10, 9 ... 3; tc high exactly one cycle after the d = 3 edge; busy falls; d holds 3.
REQ-031 Bench SHALL cover auto-reload: b = 5, l = 2, auto = 1, en = 1 -> d = 5, 4, 3, 2, 5, 4 ...; tc pulses every 4 cycles; busy stays 1.
REQ-032 Bench SHALL cover wrap: b = 1, l = 14, auto = 0 -> d = 1, 0, 15, 14; tc after 4 enabled cycles; then DONE.
REQ-033 Bench SHALL cover enable gating: b = 6, l = 0, en toggling 1/0 every cycle -> d decrements only on en = 1 edges; tc after 7 enabled edges; d holds during en = 0.
REQ-034 Bench SHALL cover load collision: load b = 9 on the same edge where d == l_q and en = 1 -> d = 9, tc stays 0, RUN.
REQ-035 Bench SHALL cover async reset: rst pulsed low between edges mid-count (d = 7) -> d = 0, tc = 0, busy = 0 immediately; later en = 1 without load -> d stays 0.

Source files
------------

// File: rtl/four_bit_down_counter_pkg.sv
// Shared width constant and state encoding for the four-bit down counter.
package four_bit_down_counter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/four_bit_down_counter.sv
// Loadable four-bit down counter with a captured terminal value, one-shot or
// auto-reload operation, and registered count, terminal pulse and busy outputs.
module four_bit_down_counter
    import four_bit_down_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] b,
    input  logic [CNT_W-1:0] l,
    input  logic             auto,
    output logic [CNT_W-1:0] d,
    output logic             tc,
    output logic             busy
);

    state_t           state, state_next;
    logic [CNT_W-1:0] d_next, b_q, b_q_next, l_q, l_q_next;
    logic             auto_q, auto_q_next, tc_next;

    // All outputs and captured settings live in flops; reset clears everything
    // and aborts any count in progress without a terminal pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            d      <= '0;
            tc     <= 1'b0;
            busy   <= 1'b0;
            b_q    <= '0;
            l_q    <= '0;
            auto_q <= 1'b0;
        end else begin
            state  <= state_next;
            d      <= d_next;
            tc     <= tc_next;
            busy   <= (state_next == RUN);
            b_q    <= b_q_next;
            l_q    <= l_q_next;
            auto_q <= auto_q_next;
        end
    end

    // Load wins over everything else; otherwise only an enabled RUN edge moves
    // the count, and reaching the captured terminal value produces the pulse.
    always_comb begin
        state_next  = state;
        d_next      = d;
        tc_next     = 1'b0;
        b_q_next    = b_q;
        l_q_next    = l_q;
        auto_q_next = auto_q;

        if (load) begin
            d_next      = b;
            b_q_next    = b;
            l_q_next    = l;
            auto_q_next = auto;
            state_next  = RUN;
        end else if (state == RUN && en) begin
            if (d == l_q) begin
                tc_next = 1'b1;
                if (auto_q) begin
                    d_next = b_q;
                end else begin
                    state_next = DONE;
                end
            end else begin
                d_next = d - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_four_bit_down_counter.sv
// Self-checking bench: a remaining-cycles model checked every cycle, plus
// hand-computed expectations along directed scenarios.
module tb_four_bit_down_counter;

    logic       clk, rst, en, load, auto;
    logic [3:0] b, l, d;
    logic       tc, busy;

    int testsRun = 0;
    int testsFailed = 0;
    bit checkOn = 0;

    four_bit_down_counter dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .b(b), .l(l),
        .auto(auto), .d(d), .tc(tc), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model tracks how many enabled edges remain before the terminal edge.
    logic [3:0] mD, mB;
    int         mRem, mPeriod, mState;
    bit         mAuto, mTc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mD <= 0; mB <= 0; mRem <= 0; mPeriod <= 0;
            mState <= 0; mAuto <= 0; mTc <= 0;
        end else if (load) begin
            mD      <= b;
            mB      <= b;
            mRem    <= (int'(b) - int'(l) + 16) % 16;
            mPeriod <= ((int'(b) - int'(l) + 16) % 16) + 1;
            mAuto   <= auto;
            mState  <= 1;
            mTc     <= 0;
        end else if (mState == 1 && en) begin
            if (mRem == 0) begin
                mTc <= 1;
                if (mAuto) begin
                    mD   <= mB;
                    mRem <= mPeriod - 1;
                end else begin
                    mState <= 2;
                end
            end else begin
                mD   <= 4'((int'(mD) + 15) % 16);
                mRem <= mRem - 1;
                mTc  <= 0;
            end
        end else begin
            mTc <= 0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("model_d", int'(d), int'(mD));
            checkOutput("model_tc", int'(tc), int'(mTc));
            checkOutput("model_busy", int'(busy), (mState == 1) ? 1 : 0);
        end
    end

    task automatic applyStimulus(input bit ld, input logic [3:0] bb, input logic [3:0] ll,
                                 input bit aa, input bit ee);
        load = ld; b = bb; l = ll; auto = aa; en = ee;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int autoSeq[12];
        autoSeq = '{4, 3, 2, 5, 4, 3, 2, 5, 4, 3, 2, 5};

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        tick(); tick();
        checkOn = 1;
        checkOutput("reset_d", int'(d), 0);
        checkOutput("reset_tc", int'(tc), 0);
        checkOutput("reset_busy", int'(busy), 0);

        // One-shot, loaded on the first edge after reset release
        rst = 1'b1;
        applyStimulus(1, 10, 3, 0, 1);
        tick();
        checkOutput("oneshot_load_d", int'(d), 10);
        checkOutput("oneshot_load_busy", int'(busy), 1);
        applyStimulus(0, 2, 7, 1, 1);
        repeat (7) tick();
        checkOutput("oneshot_at_l_d", int'(d), 3);
        checkOutput("oneshot_at_l_tc", int'(tc), 0);
        tick();
        checkOutput("oneshot_tc", int'(tc), 1);
        checkOutput("oneshot_hold_d", int'(d), 3);
        checkOutput("oneshot_busy_fall", int'(busy), 0);
        tick();
        checkOutput("oneshot_tc_width", int'(tc), 0);
        checkOutput("oneshot_done_d", int'(d), 3);

        // Auto-reload
        applyStimulus(1, 5, 2, 1, 1);
        tick();
        checkOutput("auto_load_d", int'(d), 5);
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput("auto_d", int'(d), autoSeq[i]);
            checkOutput("auto_tc", int'(tc), (i % 4 == 3) ? 1 : 0);
            checkOutput("auto_busy", int'(busy), 1);
        end

        // Wrap through 0 -> 15
        applyStimulus(1, 1, 14, 0, 1);
        tick();
        applyStimulus(0, 1, 14, 0, 1);
        tick(); checkOutput("wrap_d0", int'(d), 0);
        tick(); checkOutput("wrap_d15", int'(d), 15);
        tick(); checkOutput("wrap_d14", int'(d), 14);
        tick();
        checkOutput("wrap_tc", int'(tc), 1);
        checkOutput("wrap_done_busy", int'(busy), 0);

        // Enable gating
        applyStimulus(1, 6, 0, 0, 0);
        tick();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, 6, 0, 0, (i % 2 == 0));
            tick();
            if (i == 1) checkOutput("gate_hold_d", int'(d), 5);
            if (i == 11) checkOutput("gate_pre_tc", int'(tc), 0);
            if (i == 12) checkOutput("gate_tc", int'(tc), 1);
        end
        checkOutput("gate_end_busy", int'(busy), 0);

        // Load collides with terminal edge
        applyStimulus(1, 5, 3, 0, 1);
        tick();
        applyStimulus(0, 5, 3, 0, 1);
        tick(); tick();
        checkOutput("coll_pre_d", int'(d), 3);
        applyStimulus(1, 9, 4, 0, 1);
        tick();
        checkOutput("coll_d", int'(d), 9);
        checkOutput("coll_tc", int'(tc), 0);
        checkOutput("coll_busy", int'(busy), 1);

        // Asynchronous reset mid-count
        applyStimulus(0, 9, 4, 0, 1);
        tick(); tick();
        applyStimulus(0, 9, 4, 0, 0);
        checkOutput("areset_pre_d", int'(d), 7);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("areset_d", int'(d), 0);
        checkOutput("areset_tc", int'(tc), 0);
        checkOutput("areset_busy", int'(busy), 0);
        #1 rst = 1'b1;
        applyStimulus(0, 9, 4, 0, 1);
        repeat (3) tick();
        checkOutput("areset_idle_d", int'(d), 0);
        checkOutput("areset_idle_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
